// File: rtl/tapper_pkg.sv
// Shared definitions for the tapper game-logic slice.
// Contents:
//   state_t     : tile_sequencer FSM states
//   tile_t      : one falling-tile queue entry {lane, y}
//   screen and lane geometry defaults (160x120 screen, four lanes)
//   lane_x()    : left-edge x pixel of a lane, truncated to 8 bits
package tapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_UPDATE    = 3'd2,
    ST_DRAW      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  localparam int SCR_W      = 160;
  localparam int SCR_H      = 120;
  localparam int NUM_LANES  = 4;
  localparam int QDEPTH     = 4;
  localparam int DEF_X0     = 40;
  localparam int DEF_LANE_W = 20;
  localparam int DEF_TILE_H = 10;

  typedef struct packed {
    logic [1:0] lane;
    logic [6:0] y;
  } tile_t;

  function automatic logic [7:0] lane_x(input logic [1:0] lane, input int x0, input int lane_w);
    return 8'(x0 + int'(lane) * lane_w);
  endfunction

endpackage

// File: rtl/tile_sequencer_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
// Ports:
//   clk      system clock
//   clear_b  asynchronous active-low reset, loads seed
//   en       advance one step this cycle
//   seed     reset value (must be nonzero, normally a constant)
//   q        current state
module lfsr8 (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b)
      q <= seed;
    else if (en)
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/tile_sequencer.sv
// tile_sequencer: game-logic stage feeding drawGame.
// Owns a 4-entry circular queue of falling tiles, moves them on rate-divider
// ticks, spawns tiles in LFSR-chosen lanes, judges taps against the oldest
// tile and keeps the score.
// Ports:
//   clk, clear_b     clock, asynchronous active-low reset
//   start            level, begins a game from IDLE/OVER
//   tick             one-cycle movement pulse
//   key_n[3:0]       active-low player keys (synchronised)
//   done             drawGame frame-complete pulse
//   go               one-cycle redraw request
//   x1..x4, y1..y4   tile positions, slot 1 = oldest
//   valid[3:0]       slot occupancy, bit0 = slot 1
//   score[7:0]       hit count, saturating
//   gd               game over level
module tile_sequencer
  import tapper_pkg::*;
#(
  parameter int         X0        = DEF_X0,
  parameter int         LANE_W    = DEF_LANE_W,
  parameter int         TILE_H    = DEF_TILE_H,
  parameter int         STEP      = 1,
  parameter int         SPAWN_GAP = 30,
  parameter int         HIT_Y     = 100,
  parameter int         MISS_Y    = 110,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] key_n,
  input  logic       done,
  output logic       go,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [6:0] y1,
  output logic [6:0] y2,
  output logic [6:0] y3,
  output logic [6:0] y4,
  output logic [3:0] valid,
  output logic [7:0] score,
  output logic       gd
);

  localparam logic [6:0] STEP7   = 7'(STEP);
  localparam logic [7:0] TILE_H8 = 8'(TILE_H);
  localparam logic [7:0] HIT_Y8  = 8'(HIT_Y);
  localparam logic [6:0] MISS_Y7 = 7'(MISS_Y);
  localparam logic [6:0] GAP7    = 7'(SPAWN_GAP);

  state_t                         state;
  tile_t [QDEPTH-1:0]             q;
  logic  [1:0]                    head;
  logic  [2:0]                    cnt;
  logic  [NUM_LANES-1:0]          key_prev, key_pend, press;
  logic                           tick_pend;
  logic  [QDEPTH-1:0][7:0]        xs;
  logic  [QDEPTH-1:0][6:0]        ys;

  // ---------------------------------------------------------------------------
  // Lane generator: steps once per UPDATE so the lane sequence depends only on
  // how many updates have happened since reset.
  // ---------------------------------------------------------------------------
  logic [7:0] lfsr;
  logic       lfsr_en;
  logic       unused_lfsr;

  assign lfsr_en     = (state == ST_UPDATE);
  assign unused_lfsr = ^lfsr[7:2];

  lfsr8 u_lfsr (
    .clk     (clk),
    .clear_b (clear_b),
    .en      (lfsr_en),
    .seed    (LFSR_SEED),
    .q       (lfsr)
  );

  // Falling edge of each active-low key.
  assign press = key_prev & ~key_n;

  // ---------------------------------------------------------------------------
  // Tap judge: exactly one lane pressed, matching the head, low enough.
  // ---------------------------------------------------------------------------
  logic       one_hot, hit;
  logic [1:0] key_lane;
  tile_t      head_t;

  always_comb begin
    key_lane = 2'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (key_pend[i]) key_lane = 2'(i);
  end

  assign one_hot = (key_pend != '0) && ((key_pend & (key_pend - 4'd1)) == '0);
  assign head_t  = q[head];
  assign hit     = one_hot && (cnt != 3'd0) && (head_t.lane == key_lane) &&
                   (({1'b0, head_t.y} + TILE_H8) >= HIT_Y8);

  // ---------------------------------------------------------------------------
  // Next queue for an UPDATE cycle: key first, then the move and spawn applied
  // to whatever is left.
  // ---------------------------------------------------------------------------
  tile_t [QDEPTH-1:0] nq;
  logic  [1:0]        nhead, newest, idx;
  logic  [2:0]        ncnt;
  logic  [7:0]        nscore;
  logic               nover;

  always_comb begin
    nq     = q;
    nhead  = head;
    ncnt   = cnt;
    nscore = score;
    nover  = 1'b0;
    newest = 2'd0;
    idx    = 2'd0;
    if (key_pend != '0) begin
      if (hit) begin
        nhead = head + 2'd1;
        ncnt  = cnt - 3'd1;
        if (score != 8'hFF) nscore = score + 8'd1;
      end else begin
        nover = 1'b1;
      end
    end
    if (tick_pend && !nover) begin
      for (int k = 0; k < QDEPTH; k++) begin
        idx = nhead + 2'(k);
        if (3'(k) < ncnt) nq[idx].y = nq[idx].y + STEP7;
      end
      // With a full queue ncnt[1:0] wraps to 0 and newest lands on head-1.
      newest = nhead + ncnt[1:0] - 2'd1;
      if (ncnt != 3'd0 && nq[nhead].y > MISS_Y7) begin
        nover = 1'b1;
      end else if (ncnt == 3'd0 || (nq[newest].y >= GAP7 && ncnt < 3'd4)) begin
        nq[nhead + ncnt[1:0]] = '{lane: lfsr[1:0], y: 7'd0};
        ncnt = ncnt + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame view: either the post-UPDATE queue or a fresh one-tile game.
  // Re-ordered so slot 0 is the head; empty slots read as zero.
  // ---------------------------------------------------------------------------
  logic               do_start, load;
  tile_t [QDEPTH-1:0] lq;
  logic  [1:0]        lhead;
  logic  [2:0]        lcnt;
  logic  [QDEPTH-1:0][7:0] slot_x;
  logic  [QDEPTH-1:0][6:0] slot_y;
  logic  [QDEPTH-1:0]      slot_live;

  assign do_start = (state == ST_IDLE || state == ST_OVER) && start;
  assign load     = do_start || (state == ST_UPDATE && !nover);

  always_comb begin
    if (state == ST_UPDATE) begin
      lq    = nq;
      lhead = nhead;
      lcnt  = ncnt;
    end else begin
      lq    = '0;
      lq[0] = '{lane: lfsr[1:0], y: 7'd0};
      lhead = 2'd0;
      lcnt  = 3'd1;
    end
  end

  for (genvar s = 0; s < QDEPTH; s++) begin : g_slot
    tile_t t;
    assign t            = lq[lhead + 2'(s)];
    assign slot_live[s] = 3'(s) < lcnt;
    assign slot_x[s]    = slot_live[s] ? lane_x(t.lane, X0, LANE_W) : 8'd0;
    assign slot_y[s]    = slot_live[s] ? t.y : 7'd0;
  end

  // ---------------------------------------------------------------------------
  // FSM, pending flags and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state     <= ST_IDLE;
      q         <= '0;
      head      <= 2'd0;
      cnt       <= 3'd0;
      key_prev  <= 4'hF;
      key_pend  <= '0;
      tick_pend <= 1'b0;
      score     <= 8'd0;
      go        <= 1'b0;
      gd        <= 1'b0;
      valid     <= '0;
      xs        <= '0;
      ys        <= '0;
    end else begin
      key_prev <= key_n;
      go       <= 1'b0;

      // Only the first press is kept until UPDATE consumes it; extra ticks
      // collapse into the single pending flag.
      if (state == ST_PLAY || state == ST_WAIT_DONE) begin
        if (key_pend == '0 && press != '0) key_pend <= press;
        if (tick) tick_pend <= 1'b1;
      end

      if (load) begin
        xs    <= slot_x;
        ys    <= slot_y;
        valid <= slot_live;
      end

      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            q         <= lq;
            head      <= 2'd0;
            cnt       <= 3'd1;
            score     <= 8'd0;
            gd        <= 1'b0;
            key_pend  <= '0;
            tick_pend <= 1'b0;
            go        <= 1'b1;
            state     <= ST_DRAW;
          end
        end
        ST_PLAY: begin
          if (key_pend != '0 || tick_pend) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          q         <= nq;
          head      <= nhead;
          cnt       <= ncnt;
          score     <= nscore;
          key_pend  <= '0;
          tick_pend <= 1'b0;
          // Game over keeps the last drawn frame on the outputs.
          if (nover) begin
            gd    <= 1'b1;
            state <= ST_OVER;
          end else begin
            go    <= 1'b1;
            state <= ST_DRAW;
          end
        end
        ST_DRAW:      state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (done) state <= ST_PLAY;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  assign x1 = xs[0];
  assign x2 = xs[1];
  assign x3 = xs[2];
  assign x4 = xs[3];
  assign y1 = ys[0];
  assign y2 = ys[1];
  assign y3 = ys[2];
  assign y4 = ys[3];

endmodule

// File: tb/tb_tile_sequencer.sv
// Testbench for tile_sequencer: directed table, hand sequences for reset and
// replay, and randomized frames checked against a queue-based game model.
module tb_tile_sequencer;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       done = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       go, gd;
  logic [7:0] x1, x2, x3, x4, score;
  logic [6:0] y1, y2, y3, y4;
  logic [3:0] valid;

  tile_sequencer dut (
    .clk(clk), .clear_b(clear_b), .start(start), .tick(tick), .key_n(key_n),
    .done(done), .go(go), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .valid(valid), .score(score), .gd(gd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: plain lists of tiles, oldest first.
  int         mlane[$], my[$];
  int         plane[$], py[$];
  int         mscore;
  logic [7:0] mlfsr;
  bit         mover;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_x(input int k);
    case (k)
      0: return int'(x1);
      1: return int'(x2);
      2: return int'(x3);
      default: return int'(x4);
    endcase
  endfunction

  function automatic int dut_y(input int k);
    case (k)
      0: return int'(y1);
      1: return int'(y2);
      2: return int'(y3);
      default: return int'(y4);
    endcase
  endfunction

  // Taps 8,6,5,4 in 1-based numbering; new bit enters at the bottom.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic fb;
    fb = v[8-1] ^ v[6-1] ^ v[5-1] ^ v[4-1];
    return {v[6:0], fb};
  endfunction

  task automatic model_start();
    mlane.delete(); my.delete();
    mscore = 0;
    mover  = 0;
    mlane.push_back(int'(mlfsr[1:0]));
    my.push_back(0);
  endtask

  task automatic model_update(input logic [3:0] km, input bit tk);
    mover = 0;
    plane = mlane;
    py    = my;
    if (km != 4'd0) begin
      if ($countones(km) == 1 && mlane.size() > 0 && km == (4'd1 << mlane[0]) &&
          my[0] + 10 >= 100) begin
        void'(mlane.pop_front());
        void'(my.pop_front());
        if (mscore < 255) mscore++;
      end else begin
        mover = 1;
      end
    end
    if (tk && !mover) begin
      foreach (my[i]) my[i] += 1;
      if (my.size() > 0 && my[0] > 110)
        mover = 1;
      else if (my.size() == 0 || (my[my.size()-1] >= 30 && my.size() < 4)) begin
        mlane.push_back(int'(mlfsr[1:0]));
        my.push_back(0);
      end
    end
    mlfsr = lfsr_next(mlfsr);
  endtask

  task automatic check_view(input string tag);
    chk({tag, "_valid"}, int'(valid), (1 << mlane.size()) - 1);
    chk({tag, "_score"}, int'(score), mscore);
    chk({tag, "_gd"}, int'(gd), 0);
    for (int k = 0; k < mlane.size(); k++) begin
      chk($sformatf("%s_x%0d", tag, k + 1), dut_x(k), 40 + 20 * mlane[k]);
      chk($sformatf("%s_y%0d", tag, k + 1), dut_y(k), my[k]);
    end
  endtask

  task automatic wait_go(output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (go) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("go_seen", int'(ok), 1);
  endtask

  task automatic do_start();
    bit ok;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_start();
    wait_go(ok);
    if (ok) begin
      check_view("start");
      @(negedge clk);
      chk("go_one_cycle", int'(go), 0);
    end
  endtask

  // One frame: stimulus while drawGame is busy, then done, then the result.
  task automatic frame(input logic [3:0] km, input int nt);
    bit ok;
    int gocnt;
    @(negedge clk);
    for (int i = 0; i < nt; i++) begin
      tick = 1'b1; @(negedge clk);
      tick = 1'b0; @(negedge clk);
    end
    if (km != 4'd0) begin
      key_n = ~km; @(negedge clk);
      key_n = 4'hF; @(negedge clk);
    end
    chk("hold_go", int'(go), 0);
    if (my.size() > 0) chk("hold_y1", int'(y1), my[0]);
    done = 1'b1; @(negedge clk);
    done = 1'b0;
    model_update(km, nt > 0);
    if (!mover) begin
      wait_go(ok);
      if (ok) check_view("frame");
    end else begin
      gocnt = 0;
      for (int c = 0; c < 8; c++) begin
        if (go) gocnt++;
        @(negedge clk);
      end
      chk("over_no_go", gocnt, 0);
      chk("over_gd", int'(gd), 1);
      chk("over_score", int'(score), mscore);
      chk("over_valid", int'(valid), (1 << plane.size()) - 1);
      for (int k = 0; k < plane.size(); k++) begin
        chk($sformatf("over_x%0d", k + 1), dut_x(k), 40 + 20 * plane[k]);
        chk($sformatf("over_y%0d", k + 1), dut_y(k), py[k]);
      end
    end
  endtask

  typedef struct {
    bit         restart;
    int         reps;
    logic [3:0] key;
    int         ticks;
    logic [3:0] e_valid;
    int         e_y1;
    int         e_y2;
    int         e_score;
    bit         e_gd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] km;
    int         nt, r;
    bit         ok;

    // Head starts in lane 1 (seed A5); rows follow one game then a miss game.
    tbl[0] = '{0, 29, 4'b0000, 1, 4'b0001,  29, -1, 0, 0};
    tbl[1] = '{0,  1, 4'b0000, 2, 4'b0011,  30,  0, 0, 0};
    tbl[2] = '{0, 30, 4'b0000, 1, 4'b0111,  60, 30, 0, 0};
    tbl[3] = '{0, 30, 4'b0000, 1, 4'b1111,  90, 60, 0, 0};
    tbl[4] = '{0,  2, 4'b0000, 1, 4'b1111,  92, 62, 0, 0};
    tbl[5] = '{0,  1, 4'b0010, 0, 4'b0111,  62, 32, 1, 0};
    tbl[6] = '{0,  1, 4'b0001, 0, 4'b0111,  62, 32, 1, 1};
    tbl[7] = '{1, 110, 4'b0000, 1, 4'b1111, 110, 80, 0, 0};
    tbl[8] = '{0,  1, 4'b0000, 1, 4'b1111, 110, 80, 0, 1};

    mlfsr = 8'hA5;
    mover = 0;

    // Reset state.
    #2;
    chk("rst_go", int'(go), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_gd", int'(gd), 0);
    chk("rst_x1", int'(x1), 0);
    chk("rst_y1", int'(y1), 0);

    @(negedge clk); clear_b = 1'b1;
    // A press in IDLE must not leak into the first game.
    @(negedge clk); key_n = 4'b1110;
    @(negedge clk); key_n = 4'hF;

    do_start();
    chk("start_x1", int'(x1), 60);
    chk("start_y1", int'(y1), 0);
    chk("start_valid", int'(valid), 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].restart) do_start();
      for (int j = 0; j < tbl[i].reps; j++) frame(tbl[i].key, tbl[i].ticks);
      chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_y1", i), int'(y1), tbl[i].e_y1);
      if (tbl[i].e_y2 >= 0) chk($sformatf("tbl%0d_y2", i), int'(y2), tbl[i].e_y2);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].e_score);
      chk($sformatf("tbl%0d_gd", i), int'(gd), int'(tbl[i].e_gd));
    end

    // Randomized play.
    for (int f = 0; f < 400; f++) begin
      if (mover) begin
        @(negedge clk); key_n = ~(4'd1 << $urandom_range(0, 3));
        @(negedge clk); key_n = 4'hF;
        do_start();
      end
      r  = int'($urandom_range(0, 99));
      km = 4'd0;
      nt = 0;
      if (my.size() > 0 && my[0] + 10 >= 100 && r < 70) begin
        km = 4'd1 << mlane[0];
        nt = int'($urandom_range(0, 2));
      end else if (r == 0) begin
        km = 4'd1 << $urandom_range(0, 3);
        nt = int'($urandom_range(0, 1));
      end else if (r == 1) begin
        km = 4'b0011 << $urandom_range(0, 2);
        nt = int'($urandom_range(0, 1));
      end else begin
        nt = int'($urandom_range(1, 2));
      end
      frame(km, nt);
    end

    // Asynchronous clear while waiting on drawGame.
    if (mover) begin
      do_start();
      frame(4'd0, 1);
    end
    @(negedge clk); clear_b = 1'b0;
    #1;
    chk("clr_go", int'(go), 0);
    chk("clr_valid", int'(valid), 0);
    chk("clr_score", int'(score), 0);
    chk("clr_gd", int'(gd), 0);
    chk("clr_x1", int'(x1), 0);
    chk("clr_y1", int'(y1), 0);
    @(negedge clk);
    chk("clr_go_held", int'(go), 0);
    clear_b = 1'b1;

    // Same seed after reset: lane sequence replays.
    mlfsr = 8'hA5;
    do_start();
    chk("replay_x1", int'(x1), 60);
    for (int f = 0; f < 100; f++) frame(4'd0, 1);

    wait_go(ok);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Game-logic stage directly upstream of drawGame.
- Owns the falling-tile queue (up to 4 tiles), advances it on rate-divider ticks, and spawns new tiles in pseudo-random lanes.
- Judges player taps against the lowest tile and keeps the score.
- Feeds drawGame with x1..y4, go and gd, and consumes its done.

Parameters:
- X0, 40: x pixel of lane 0 left edge
- LANE_W, 20: x pitch between lanes
- TILE_H, 10: tile height in pixels
- STEP, 1: pixels moved per tick
- SPAWN_GAP, 30: newest tile's y must reach this before the next spawn
- HIT_Y, 100: the oldest tile's bottom edge (y+TILE_H) must be >= this for a tap to count
- MISS_Y, 110: oldest tile y > this after a move means game over
- LFSR_SEED, 8'hA5: LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock
- clear_b  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE/OVER to begin a game
- tick  in  1  one-cycle pulse from ratedivider, i.e. the movement cadence
- key_n  in  4  player keys, active-low, already synchronised
- done  in  1  drawGame finished a frame, one-cycle pulse
- go  out  1  one-cycle request to drawGame to redraw
- x1..x4  out  8 each  tile x, slot 1 = oldest
- y1..y4  out  7 each  tile y (top edge)
- valid  out  4  slot occupied mask, bit0 = slot 1
- score  out  8  hits, saturating at 255
- gd  out  1  game over, level

Behaviour:
- Reset:
  - state IDLE; all queue entries invalid.
  - x/y/valid/score/go/gd = 0; lfsr = LFSR_SEED.
  - key history = 4'hF, tick_pend = 0, key_pend = 0.
- Key edge: press = prev & ~key_n (falling edge), one flag per lane.
  - In PLAY/WAIT_DONE, the first cycle with any press latches into key_pend (4 bits) if key_pend is empty.
  - Later presses are ignored until key_pend is consumed.
  - Presses in IDLE/OVER are discarded.
- tick in PLAY/WAIT_DONE sets tick_pend. Multiple ticks collapse into one.
- Queue: 4-entry circular buffer, each entry {lane[1:0], y[6:0]}, with head = oldest. Outputs are re-ordered so slot 1 = head.
  - x = X0 + lane*LANE_W, computed in 8 bits.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances once per UPDATE. Spawn lane = lfsr[1:0].
- FSM:
  - IDLE: on start, clear the queue and score, spawn one tile at y=0, then go to DRAW.
  - PLAY: if key_pend != 0 or tick_pend = 1, go to UPDATE.
  - UPDATE (1 cycle), steps in order:
    - (a) If key_pend != 0:
      - Hit when exactly one bit is set (bit i), head is valid, head.lane == i, and head.y+TILE_H >= HIT_Y.
      - On a hit: pop head, score++ (saturating), clear key_pend.
      - Any other key_pend is a wrong tap and goes to OVER.
    - (b) If tick_pend: every valid y += STEP, then clear tick_pend.
      - If the head (after a pop in (a)) has y > MISS_Y, go to OVER.
      - Spawn at y=0 if the queue is empty or (newest.y >= SPAWN_GAP and count < 4).
    - Then go to DRAW. Outputs are registered at the end of UPDATE.
  - DRAW: go = 1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: x/y/valid are held stable. On done, go to PLAY. Pending flags still accumulate.
  - OVER: gd = 1, all outputs frozen, go = 0. On start, take the same path as IDLE start (gd cleared in the same cycle).
- Queue full (4 valid): spawn suppressed, no error.
- Empty queue plus a key press is a wrong tap and goes to OVER.
- A key and a tick pending in the same UPDATE: the key is resolved first, then the move is applied to the remaining tiles.
- clear_b low at any time forces reset values immediately. No go pulse is produced while in reset.
- Latency:
  - key press edge to score update: the press edge is latched into key_pend first.
  - Then at most 2 cycles (PLAY→UPDATE) if the FSM is in PLAY.
  - Otherwise the key waits for done.

Decomposition:
- Shared package (tapper_pkg):
  - state encoding
  - screen constants: 160x120 and the lane geometry defaults
  - the queue entry struct {lane, y}
- One sub-module: lfsr8 (clk, clear_b, en, seed → q).
- Queue, judge and FSM stay in tile_sequencer.

Test Plan:
- Reset then start=1 for one cycle:
  - go pulses once.
  - valid=4'b0001, y1=0, x1 = 40 + 20*(lane from the LFSR seed).
- Start, then 30 ticks, each acknowledged with done:
  - y1=30.
  - The next UPDATE spawns, so valid=4'b0011, y2=0.
  - A tick arriving while in WAIT_DONE is applied only after done.
- Advance the head to y=92 (bottom 102), then press the matching key:
  - score=1 and the head is popped.
  - The next frame shows the former slot 2 as slot 1.
- Press the wrong lane, or press with head y=50:
  - gd=1, score unchanged.
  - Outputs frozen and no further go pulses.
- Let the head reach y=111 with no press: gd=1 on that UPDATE.
- Assert clear_b=0 mid-WAIT_DONE:
  - All outputs go to 0 asynchronously and the FSM returns to IDLE.
  - After release, start replays an identical lane sequence (same seed).
